// File: rtl/filter_stream_master.sv
// Streams one frame of pixels from a source memory to a filter and writes the
// filtered results back in order, with a two-entry skid buffer on the pixel path.
module filter_stream_master #(
  parameter int ADDR_W = 20,
  parameter int DIM_W  = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DIM_W-1:0]  i_width,
  input  logic [DIM_W-1:0]  i_height,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [23:0]       i_mem_data,
  output logic              o_rgb_vld,
  output logic [24:0]       o_rgb_data,
  input  logic              i_rgb_busy,
  input  logic              i_result_vld,
  input  logic [23:0]       i_result_data,
  output logic              o_result_busy,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [23:0]       o_wr_data,
  output logic              o_active,
  output logic              o_done
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [2*DIM_W-1:0]  w_prod;
  logic [CW-1:0]       w_start_n;
  logic [CW-1:0]       r_n;
  logic [CW-1:0]       r_rd_cnt;
  logic [CW-1:0]       r_tx_cnt;
  logic [CW-1:0]       r_rx_cnt;

  logic                r_dv;
  logic                r_dv_last;
  logic                r_out_vld;
  logic [24:0]         r_out_data;
  logic                r_skid_vld;
  logic [24:0]         r_skid_data;
  logic [24:0]         w_in;

  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [23:0]         r_wr_data;

  logic                w_accept;
  logic                w_xfer;
  logic                w_rx;
  logic                w_rd_raw;
  logic                w_rd_last;
  logic [1:0]          w_occ;

  assign w_prod    = {{DIM_W{1'b0}}, i_width} * {{DIM_W{1'b0}}, i_height};
  assign w_start_n = CW'(w_prod);
  assign w_accept  = (r_state == S_IDLE) && i_start;
  assign w_xfer    = r_out_vld && !i_rgb_busy;
  assign w_rx      = i_result_vld && !o_result_busy;
  assign w_in      = {r_dv_last, i_mem_data};

  // Entries held after this edge: output reg + skid + read whose data arrives now.
  assign w_occ = {1'b0, r_out_vld} + {1'b0, r_skid_vld} + {1'b0, r_dv} - {1'b0, w_xfer};

  assign o_mem_rd   = w_rd_raw && !i_rst;
  assign o_rgb_vld  = r_out_vld;
  assign o_rgb_data = r_out_data;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = (w_start_n == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if ((r_tx_cnt == r_n) && (r_rx_cnt == r_n)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // The first read is issued from IDLE so the first pixel appears two cycles after start.
  always_comb begin
    o_active      = 1'b0;
    o_done        = 1'b0;
    o_result_busy = 1'b1;
    o_mem_addr    = '0;
    w_rd_raw      = 1'b0;
    w_rd_last     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rd_raw  = i_start && (w_start_n != '0);
        w_rd_last = (w_start_n == CW'(1));
      end
      S_RUN: begin
        o_active      = 1'b1;
        o_result_busy = !(r_rx_cnt < r_n);
        w_rd_raw      = (r_rd_cnt < r_n) && (w_occ < 2'd2);
        w_rd_last     = (r_rd_cnt == r_n - CW'(1));
        o_mem_addr    = r_rd_cnt[ADDR_W-1:0];
      end
      S_DONE: begin
        o_active = 1'b1;
        o_done   = 1'b1;
      end
      default: begin
        o_active = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_n      <= '0;
      r_rd_cnt <= '0;
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_n      <= w_start_n;
        r_rd_cnt <= o_mem_rd ? CW'(1) : '0;
        r_tx_cnt <= '0;
        r_rx_cnt <= '0;
      end else begin
        if (o_mem_rd) begin
          r_rd_cnt <= r_rd_cnt + CW'(1);
        end
        if (w_xfer) begin
          r_tx_cnt <= r_tx_cnt + CW'(1);
        end
        if (w_rx) begin
          r_rx_cnt <= r_rx_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dv        <= 1'b0;
      r_dv_last   <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
    end else begin
      r_dv      <= o_mem_rd;
      r_dv_last <= o_mem_rd && w_rd_last;
      if (!r_out_vld || w_xfer) begin
        if (r_skid_vld) begin
          r_out_vld   <= 1'b1;
          r_out_data  <= r_skid_data;
          r_skid_vld  <= r_dv;
          r_skid_data <= w_in;
        end else begin
          r_out_vld <= r_dv;
          if (r_dv) begin
            r_out_data <= w_in;
          end
        end
      end else if (r_dv) begin
        // Output is stalled; the returning read parks in the skid entry.
        r_skid_vld  <= 1'b1;
        r_skid_data <= w_in;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_rx;
      if (w_rx) begin
        r_wr_addr <= r_rx_cnt[ADDR_W-1:0];
        r_wr_data <= i_result_data;
      end
    end
  end

endmodule

// File: tb/tb_filter_stream_master.sv
// Frame-level bench: memory and echo-filter models, scoreboard queues for pixels
// and writes, a table of frames plus abort and ignored-input sequences.
module tb_filter_stream_master;
  localparam int ADDR_W = 20;
  localparam int DIM_W  = 10;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_start = 1'b0;
  logic [DIM_W-1:0]  i_width = '0;
  logic [DIM_W-1:0]  i_height = '0;
  logic              o_mem_rd;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [23:0]       i_mem_data = '0;
  logic              o_rgb_vld;
  logic [24:0]       o_rgb_data;
  logic              i_rgb_busy = 1'b0;
  logic              i_result_vld = 1'b0;
  logic [23:0]       i_result_data = '0;
  logic              o_result_busy;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [23:0]       o_wr_data;
  logic              o_active;
  logic              o_done;

  always #5 clk = ~clk;

  filter_stream_master #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_width(i_width), .i_height(i_height),
    .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
    .o_rgb_vld(o_rgb_vld), .o_rgb_data(o_rgb_data), .i_rgb_busy(i_rgb_busy),
    .i_result_vld(i_result_vld), .i_result_data(i_result_data), .o_result_busy(o_result_busy),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_active(o_active), .o_done(o_done)
  );

  typedef struct {
    int        due;
    logic [23:0] data;
  } res_t;

  typedef struct {
    int w;
    int h;
    int pct;
    bit glitch;
    int exp_n;
  } frame_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int busy_pct = 0;
  bit inject = 1'b0;
  res_t res_q[$];
  bit res_taken = 1'b0;
  logic [24:0] exp_px[$];
  logic [ADDR_W+23:0] exp_wr[$];
  int rd_cnt = 0, xfer_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int start_cyc = 0, first_vld_cyc = -1, first_xfer_cyc = 0, last_xfer_cyc = 0;
  int last_wr_cyc = 0, done_cyc = -1, exp_rd_addr = 0;
  bit mem_pend = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  bit prev_hold = 1'b0;
  logic [24:0] prev_data = '0;

  function automatic logic [23:0] pix(input int a);
    pix = 24'(a * 32'h0001_0307 + 32'h0012_3456);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event occurred, none expected (cycle %0d)", name, cyc);
  endtask

  // Monitor / scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (i_rst) begin
      exp_px.delete();
      exp_wr.delete();
      res_q.delete();
      res_taken = 1'b0;
      mem_pend  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (i_start && !o_active) start_cyc = cyc;
      if (o_rgb_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (prev_hold) begin
        check("hold_vld", 64'(o_rgb_vld), 64'd1);
        check("hold_data", 64'(o_rgb_data), 64'(prev_data));
      end
      prev_hold = o_rgb_vld && i_rgb_busy;
      prev_data = o_rgb_data;
      mem_pend  = o_mem_rd;
      mem_addr  = o_mem_addr;
      if (o_mem_rd) begin
        check("rd_addr", 64'(o_mem_addr), 64'(exp_rd_addr));
        exp_rd_addr++;
        rd_cnt++;
      end
      if (o_rgb_vld && !i_rgb_busy) begin
        if (exp_px.size() == 0) fail("px_extra");
        else check("px", 64'(o_rgb_data), 64'(exp_px.pop_front()));
        res_q.push_back('{cyc + 3, ~o_rgb_data[23:0]});
        if (xfer_cnt == 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        xfer_cnt++;
      end
      if (i_result_vld && !o_result_busy) res_taken = 1'b1;
      if (o_wr_en) begin
        if (exp_wr.size() == 0) fail("wr_extra");
        else check("wr", 64'({o_wr_addr, o_wr_data}), 64'(exp_wr.pop_front()));
        wr_cnt++;
        last_wr_cyc = cyc;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Memory (1-cycle read latency), echo filter (3-cycle, inverted) and busy generator
  always @(posedge clk) begin
    #1;
    cyc++;
    i_mem_data = mem_pend ? pix(int'(mem_addr)) : 24'hdead5a;
    if (res_taken) begin
      void'(res_q.pop_front());
      res_taken = 1'b0;
    end
    if (res_q.size() > 0 && res_q[0].due <= cyc) begin
      i_result_vld  = 1'b1;
      i_result_data = res_q[0].data;
    end else begin
      i_result_vld  = inject;
      i_result_data = inject ? 24'h00abcd : 24'h0;
    end
    i_rgb_busy = (busy_pct > 0) && ($urandom_range(99) < busy_pct);
  end

  task automatic clear_stats();
    rd_cnt = 0; xfer_cnt = 0; wr_cnt = 0; done_cnt = 0;
    first_vld_cyc = -1; done_cyc = -1; exp_rd_addr = 0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_mem_rd"}, 64'(o_mem_rd), 64'd0);
    check({pfx, "_mem_addr"}, 64'(o_mem_addr), 64'd0);
    check({pfx, "_rgb_vld"}, 64'(o_rgb_vld), 64'd0);
    check({pfx, "_rgb_data"}, 64'(o_rgb_data), 64'd0);
    check({pfx, "_result_busy"}, 64'(o_result_busy), 64'd1);
    check({pfx, "_wr_en"}, 64'(o_wr_en), 64'd0);
    check({pfx, "_wr_addr"}, 64'(o_wr_addr), 64'd0);
    check({pfx, "_wr_data"}, 64'(o_wr_data), 64'd0);
    check({pfx, "_active"}, 64'(o_active), 64'd0);
    check({pfx, "_done"}, 64'(o_done), 64'd0);
  endtask

  task automatic run_frame(input int w, input int h, input int pct, input bit glitch, input int exp_n);
    @(posedge clk); #1;
    busy_pct = pct;
    clear_stats();
    for (int i = 0; i < w * h; i++) begin
      exp_px.push_back({(i == w * h - 1), pix(i)});
      exp_wr.push_back({ADDR_W'(i), ~pix(i)});
    end
    i_width = DIM_W'(w); i_height = DIM_W'(h); i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0; i_width = 10'd7; i_height = 10'd7;
    if (glitch) begin
      repeat (3) @(posedge clk);
      #1 i_start = 1'b1; i_width = 10'd1; i_height = 10'd1;
      @(posedge clk); #1 i_start = 1'b0;
    end
    for (int c = 0; c < 2000 && done_cnt == 0; c++) @(posedge clk);
    if (done_cnt == 0) fail("done_timeout");
    repeat (4) @(posedge clk);
    busy_pct = 0;
    check("reads", 64'(rd_cnt), 64'(exp_n));
    check("pixels", 64'(xfer_cnt), 64'(exp_n));
    check("writes", 64'(wr_cnt), 64'(exp_n));
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("px_left", 64'(exp_px.size()), 64'd0);
    check("wr_left", 64'(exp_wr.size()), 64'd0);
    if (exp_n == 0) begin
      check("zero_done_lat", 64'(done_cyc), 64'(start_cyc + 1));
    end else begin
      check("done_after_wr", 64'(done_cyc), 64'(last_wr_cyc + 1));
      if (pct == 0) begin
        check("first_vld", 64'(first_vld_cyc), 64'(start_cyc + 2));
        check("burst", 64'(last_xfer_cyc - first_xfer_cyc), 64'(exp_n - 1));
      end
    end
    $display("frame %0dx%0d busy=%0d glitch=%0d: reads=%0d pixels=%0d writes=%0d done=%0d",
             w, h, pct, glitch, rd_cnt, xfer_cnt, wr_cnt, done_cnt);
  endtask

  initial begin
    frame_t tbl[7];
    tbl[0] = '{4, 2, 0, 1'b0, 8};
    tbl[1] = '{3, 3, 50, 1'b0, 9};
    tbl[2] = '{0, 5, 0, 1'b0, 0};
    tbl[3] = '{1, 1, 0, 1'b0, 1};
    tbl[4] = '{5, 1, 30, 1'b0, 5};
    tbl[5] = '{3, 3, 0, 1'b1, 9};
    tbl[6] = '{2, 3, 25, 1'b0, 6};

    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    $display("reset: outputs sampled after reset release");

    for (int t = 0; t < 7; t++) begin
      run_frame(tbl[t].w, tbl[t].h, tbl[t].pct, tbl[t].glitch, tbl[t].exp_n);
    end

    // Abort a 4x4 frame after a few pixels, then restart with a 2x2 frame
    @(posedge clk); #1;
    clear_stats();
    for (int i = 0; i < 16; i++) begin
      exp_px.push_back({(i == 15), pix(i)});
      exp_wr.push_back({ADDR_W'(i), ~pix(i)});
    end
    i_width = 10'd4; i_height = 10'd4; i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    for (int c = 0; c < 200 && xfer_cnt < 3; c++) @(posedge clk);
    if (xfer_cnt < 3) fail("abort_timeout");
    #1 i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    repeat (3) @(posedge clk);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    $display("abort: reset after %0d pixels, done=%0d", xfer_cnt, done_cnt);
    run_frame(2, 2, 0, 1'b0, 4);

    // Results offered while idle must be refused
    @(posedge clk); #1;
    wr_cnt = 0;
    inject = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_result_busy", 64'(o_result_busy), 64'd1);
    end
    @(posedge clk); #1 inject = 1'b0;
    repeat (3) @(posedge clk);
    check("idle_no_wr", 64'(wr_cnt), 64'd0);
    check("idle_inactive", 64'(o_active), 64'd0);
    $display("idle inject: writes=%0d", wr_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/filter_stream_master.md
FILTER_STREAM_MASTER -- requirements
Module: filter_stream_master

Interface
REQ-001 Parameter ADDR_W, default 20; pixel/result memory address width.
REQ-002 Parameter DIM_W, default 10; width of frame dimension inputs.
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_start  in  1  one-cycle request to stream one frame; sampled only in IDLE.
REQ-006 i_width, i_height  in  DIM_W each  frame dimensions in pixels; latched on accepted i_start.
REQ-007 o_mem_rd, o_mem_addr  out  1, ADDR_W  source pixel read strobe and address.
REQ-008 i_mem_data  in  24  pixel read data, valid exactly 1 cycle after o_mem_rd.
REQ-009 o_rgb_vld, o_rgb_data  out  1, 25  pixel stream to filter; bit 24 = last pixel of frame, bits 23:0 = RGB.
REQ-010 i_rgb_busy  in  1  filter not ready; transfer occurs on an edge with o_rgb_vld=1 and i_rgb_busy=0.
REQ-011 i_result_vld, i_result_data  in  1, 24  filtered pixel stream from filter.
REQ-012 o_result_busy  out  1  block not ready for results; transfer on edge with i_result_vld=1 and o_result_busy=0.
REQ-013 o_wr_en, o_wr_addr, o_wr_data  out  1, ADDR_W, 24  result memory write port.
REQ-014 o_active  out  1  high in every state except IDLE.
REQ-015 o_done  out  1  one-cycle pulse at frame completion.

Function
REQ-016 States: IDLE, RUN, DONE; i_start in IDLE -> RUN; RUN -> DONE when sent count and received count both equal N=width*height; DONE -> IDLE after exactly 1 cycle.
REQ-017 i_start with width=0 or height=0 -> DONE next cycle; no reads, no transfers, no writes.
REQ-018 i_start outside IDLE ignored; latched dimensions unchanged until next frame.
REQ-019 Read addresses 0..N-1 ascending, each issued exactly once per frame; reads stop after address N-1.
REQ-020 Pixel path holds a 2-entry buffer (output register + skid entry); o_mem_rd asserted only if buffered + in-flight entries < 2 after this cycle's transfer.
REQ-021 With i_rgb_busy held 0, sustained throughput 1 pixel/cycle; first o_rgb_vld at 2nd cycle after i_start accepted.
REQ-022 o_rgb_data and o_rgb_vld held stable while o_rgb_vld=1 and i_rgb_busy=1; no pixel dropped, duplicated or reordered.
REQ-023 o_rgb_data[24]=1 only for pixel N-1; 0 otherwise.
REQ-024 o_rgb_vld=0 in IDLE and DONE.
REQ-025 o_result_busy=0 in RUN while received count < N; 1 otherwise.
REQ-026 Each accepted result written same-cycle-registered: o_wr_en=1 on the following cycle, o_wr_addr=result index (0..N-1), o_wr_data=accepted data.
REQ-027 Results may arrive while pixels still being sent; sent and received counters independent, each ADDR_W+1 bits, no wrap.
REQ-028 Final result accepted -> o_wr_en for it, then DONE with o_done=1 on the cycle after the final write.
REQ-029 Simultaneous pixel transfer and result transfer in one cycle both processed.

Reset
REQ-030 i_rst=1 at an edge -> state IDLE, counters 0, buffer emptied, in-flight read discarded.
REQ-031 Reset values: o_mem_rd=0, o_mem_addr=0, o_rgb_vld=0, o_rgb_data=0, o_result_busy=1, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_active=0, o_done=0.
REQ-032 i_rst mid-frame aborts frame; no o_done; next i_start starts fresh from address 0.
REQ-033 i_rst has priority over i_start in the same cycle.

Verification
REQ-034 4x2 frame, i_rgb_busy=0, filter model echoes pixel inverted 3 cycles later -> 8 pixels on 8 consecutive cycles, bit 24 only on 8th, 8 writes addr 0..7 of ~pixel, single o_done.
REQ-035 3x3 frame, i_rgb_busy random 50% -> data stable under busy, 9 pixels in order, no duplicates; mem reads = 9.
REQ-036 i_width=0, i_height=5 -> o_done 1 cycle after start, o_mem_rd/o_rgb_vld/o_wr_en never asserted.
REQ-037 i_rst asserted after 3 of 16 pixels sent -> all outputs at reset values next cycle; new 2x2 frame completes correctly with addresses from 0.
REQ-038 i_start pulsed during RUN and i_result_vld pulsed in IDLE -> both ignored, o_result_busy=1 in IDLE, no writes.
